// File: rtl/gtxe2_chnl_tx_ctrl_pkg.sv
// GTXE2 TX control: shared state encoding,
// TXRATE decode and counter sizing.
package gtxe2_chnl_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PMA,
    RESET_PCS,
    WAIT_USERRDY,
    READY,
    RATE_HOLD,
    RATE_DONE
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // 000, 110 and 111 all select the configured default divider
  function automatic logic [2:0] rate_decode(
    input logic [2:0] rate,
    input logic [2:0] dflt
  );
    logic [2:0] d;
    unique case (rate)
      3'b001, 3'b010, 3'b011,
      3'b100, 3'b101: d = rate - 3'd1;
      default:        d = dflt;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_ctrl_if.sv
// Reset/rate request and status bundle
// between the TX channel and its sequencer.
interface gtxe2_chnl_tx_ctrl_if;
  logic       GTTXRESET;
  logic       TXPCSRESET;
  logic       TXUSERRDY;
  logic [2:0] TXRATE;
  logic       TXRATEDONE;
  logic       TXRESETDONE;
  logic       pma_reset;
  logic       pcs_reset;
  logic       line_hold;
  logic [2:0] div_sel;

  modport master (
    output GTTXRESET, TXPCSRESET,
    output TXUSERRDY, TXRATE,
    input  TXRATEDONE, TXRESETDONE,
    input  pma_reset, pcs_reset,
    input  line_hold, div_sel
  );

  modport slave (
    input  GTTXRESET, TXPCSRESET,
    input  TXUSERRDY, TXRATE,
    output TXRATEDONE, TXRESETDONE,
    output pma_reset, pcs_reset,
    output line_hold, div_sel
  );
endinterface

// File: rtl/gtxe2_chnl_tx_ctrl_cnt.sv
// Loadable down-counter with zero flag,
// shared by every timed sequencer state.
module gtxe2_chnl_tx_ctrl_cnt #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/gtxe2_chnl_tx_ctrl.sv
// GTXE2 TX reset and rate-change sequencer.
// Rate switching is built only with GTXE2_TX_RATE_CHANGE_EN.
module gtxe2_chnl_tx_ctrl
  import gtxe2_chnl_tx_ctrl_pkg::*;
#(
  parameter int PMA_RESET_CYCLES   = 16,
  parameter int PCS_RESET_CYCLES   = 8,
  parameter int RATE_SETTLE_CYCLES = 32,
  parameter int TXOUT_DIV          = 2
) (
  input logic                 TXUSRCLK,
  input logic                 reset,
  gtxe2_chnl_tx_ctrl_if.slave bus
);
  localparam int CW = cnt_width(
    PMA_RESET_CYCLES, PCS_RESET_CYCLES,
    RATE_SETTLE_CYCLES);
  localparam logic [CW-1:0] PMA_LD =
    CW'(PMA_RESET_CYCLES - 1);
  localparam logic [CW-1:0] PCS_LD =
    CW'(PCS_RESET_CYCLES - 1);
  localparam logic [2:0] DIV0 =
    3'($clog2(TXOUT_DIV));

  state_t          state;
  state_t          nxt;
  logic            ld;
  logic            zero;
  logic            busy;
  logic [CW-1:0]   ld_val;

`ifdef GTXE2_TX_RATE_CHANGE_EN
  localparam logic [CW-1:0] SET_LD =
    CW'(RATE_SETTLE_CYCLES - 1);
  logic [2:0] rate_d;
  logic [2:0] rate_q;
  logic       rate_chg;

  assign rate_d   = rate_decode(bus.TXRATE, DIV0);
  assign rate_chg = (rate_d != rate_q);
`endif

  assign busy = (state == READY) ||
                (state == RATE_HOLD) ||
                (state == RATE_DONE);

  gtxe2_chnl_tx_ctrl_cnt #(
    .W       (CW),
    .RST_VAL (PMA_LD)
  ) u_cnt (
    .clk    (TXUSRCLK),
    .rst    (reset),
    .ld     (ld),
    .ld_val (ld_val),
    .zero   (zero)
  );

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    if (bus.GTTXRESET) begin
      nxt    = RESET_PMA;
      ld     = 1'b1;
      ld_val = PMA_LD;
    end else if (bus.TXPCSRESET &&
                 state != RESET_PMA) begin
      nxt    = RESET_PCS;
      ld     = 1'b1;
      ld_val = PCS_LD;
    end else if (!bus.TXUSERRDY && busy) begin
      nxt = WAIT_USERRDY;
    end else begin
      unique case (state)
        RESET_PMA: begin
          if (zero) begin
            nxt    = RESET_PCS;
            ld     = 1'b1;
            ld_val = PCS_LD;
          end
        end
        RESET_PCS: begin
          if (zero) nxt = WAIT_USERRDY;
        end
        WAIT_USERRDY: begin
          if (bus.TXUSERRDY) nxt = READY;
        end
        READY: begin
`ifdef GTXE2_TX_RATE_CHANGE_EN
          if (rate_chg) begin
            nxt    = RATE_HOLD;
            ld     = 1'b1;
            ld_val = SET_LD;
          end
`endif
        end
`ifdef GTXE2_TX_RATE_CHANGE_EN
        // a new rate mid-settle restarts the settle window
        RATE_HOLD: begin
          if (rate_chg) begin
            ld     = 1'b1;
            ld_val = SET_LD;
          end else if (zero) begin
            nxt = RATE_DONE;
          end
        end
        RATE_DONE: nxt = READY;
`endif
        default: nxt = RESET_PMA;
      endcase
    end
  end

  always_ff @(posedge TXUSRCLK or posedge reset) begin
    if (reset) begin
      state           <= RESET_PMA;
      bus.pma_reset   <= 1'b1;
      bus.pcs_reset   <= 1'b1;
      bus.line_hold   <= 1'b1;
      bus.TXRESETDONE <= 1'b0;
      bus.TXRATEDONE  <= 1'b0;
      bus.div_sel     <= DIV0;
`ifdef GTXE2_TX_RATE_CHANGE_EN
      rate_q          <= DIV0;
`endif
    end else begin
      state           <= nxt;
      bus.pma_reset   <= (nxt == RESET_PMA);
      bus.pcs_reset   <= (nxt == RESET_PMA) ||
                         (nxt == RESET_PCS);
      bus.line_hold   <= (nxt != READY);
      bus.TXRESETDONE <= (nxt == READY) ||
                         (nxt == RATE_HOLD) ||
                         (nxt == RATE_DONE);
`ifdef GTXE2_TX_RATE_CHANGE_EN
      bus.TXRATEDONE  <= (nxt == RATE_DONE);
      // RATE_DONE holds the latch so READY sees late changes
      if (state != RATE_DONE) rate_q <= rate_d;
      if (nxt == RATE_HOLD || nxt == WAIT_USERRDY ||
          state == WAIT_USERRDY)
        bus.div_sel <= rate_d;
`else
      bus.TXRATEDONE  <= 1'b0;
      bus.div_sel     <= DIV0;
`endif
    end
  end
endmodule

// File: tb/tb_gtxe2_chnl_tx_ctrl.sv
// Self-checking bench for gtxe2_chnl_tx_ctrl.
// Rate-change scenarios run when GTXE2_TX_RATE_CHANGE_EN is defined.
module tb_gtxe2_chnl_tx_ctrl;
  typedef struct {
    int         cyc;
    logic [2:0] div;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] model_div = 3'd1;
  exp_t       sb[$];

  gtxe2_chnl_tx_ctrl_if bus();

  gtxe2_chnl_tx_ctrl #(
    .PMA_RESET_CYCLES   (16),
    .PCS_RESET_CYCLES   (8),
    .RATE_SETTLE_CYCLES (32),
    .TXOUT_DIV          (2)
  ) dut (
    .TXUSRCLK (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    bus.GTTXRESET  = 1'b0;
    bus.TXPCSRESET = 1'b0;
    bus.TXUSERRDY  = 1'b1;
    bus.TXRATE     = 3'b000;
    reset          = 1'b1;
    tick(3);
    @(negedge clk);
    got = {bus.pma_reset, bus.pcs_reset, bus.line_hold,
           bus.TXRESETDONE, bus.TXRATEDONE};
    n_cmp++;
    if (got !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want %b", got, 5'b11100);
    end
    n_cmp++;
    if (bus.div_sel !== model_div) begin
      n_bad++;
      $display("FAIL reset_div: got %0d want %0d",
               bus.div_sel, model_div);
    end
  endtask

  task automatic test_powerup();
    int   r;
    int   pma_f = -1;
    int   pcs_f = -1;
    bit   seen = 1'b0;
    exp_t e;
    tick();
    reset = 1'b0;
    r = cyc;
    sb.push_back('{r + 25, model_div});
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (pma_f < 0 && bus.pma_reset === 1'b0) pma_f = cyc;
      if (pcs_f < 0 && bus.pcs_reset === 1'b0) pcs_f = cyc;
      if (bus.TXRESETDONE === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL powerup_done_cycle: got %0d want %0d",
                   cyc - r, e.cyc - r);
        end
        n_cmp++;
        if ({bus.line_hold, bus.div_sel} !== {1'b0, e.div}) begin
          n_bad++;
          $display("FAIL powerup_ready: hold/div got %b/%0d want 0/%0d",
                   bus.line_hold, bus.div_sel, e.div);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL powerup_timeout: TXRESETDONE got 0 want 1");
      sb.delete();
    end
    n_cmp++;
    if (pma_f != r + 16) begin
      n_bad++;
      $display("FAIL pma_fall: got %0d want 16", pma_f - r);
    end
    n_cmp++;
    if (pcs_f != r + 24) begin
      n_bad++;
      $display("FAIL pcs_fall: got %0d want 24", pcs_f - r);
    end
  endtask

`ifdef GTXE2_TX_RATE_CHANGE_EN
  task automatic test_rate_change();
    int   c;
    exp_t e;
    tick();
    c = cyc;
    bus.TXRATE = 3'b011;
    model_div = 3'd2;
    sb.push_back('{c + 33, model_div});
    for (int i = 0; i < 44; i++) begin
      tick();
      @(negedge clk);
      if (cyc == c + 1) begin
        n_cmp++;
        if ({bus.line_hold, bus.div_sel} !== {1'b1, model_div}) begin
          n_bad++;
          $display("FAIL rate_entry: hold/div got %b/%0d want 1/%0d",
                   bus.line_hold, bus.div_sel, model_div);
        end
      end
      if (bus.TXRATEDONE === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rate_extra: pulse at %0d want none", cyc - c);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || bus.div_sel !== e.div) begin
            n_bad++;
            $display("FAIL rate_done: at %0d div %0d want %0d div %0d",
                     cyc - c, bus.div_sel, e.cyc - c, e.div);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL rate_missing: got no pulse want 1");
      sb.delete();
    end
    n_cmp++;
    if (bus.line_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL rate_release: line_hold got %b want 0", bus.line_hold);
    end
  endtask

  task automatic test_rate_restart();
    int   c;
    exp_t e;
    tick();
    c = cyc;
    bus.TXRATE = 3'b101;
    model_div = 3'd4;
    sb.push_back('{c + 33, model_div});
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cyc == c + 10 || cyc == c + 20) begin
        bus.TXRATE = (cyc == c + 10) ? 3'b100 : 3'b001;
        model_div = (cyc == c + 10) ? 3'd3 : 3'd0;
        if (sb.size() > 0) void'(sb.pop_back());
        sb.push_back('{cyc + 33, model_div});
      end
      @(negedge clk);
      if (cyc == c + 11 || cyc == c + 21) begin
        n_cmp++;
        if ({bus.line_hold, bus.div_sel} !== {1'b1, model_div}) begin
          n_bad++;
          $display("FAIL restart_div: at %0d hold/div %b/%0d want 1/%0d",
                   cyc - c, bus.line_hold, bus.div_sel, model_div);
        end
      end
      if (bus.TXRATEDONE === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL restart_extra: pulse at %0d want none", cyc - c);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc || bus.div_sel !== e.div) begin
            n_bad++;
            $display("FAIL restart_done: at %0d div %0d want %0d div %0d",
                     cyc - c, bus.div_sel, e.cyc - c, e.div);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL restart_missing: got no pulse want 1");
      sb.delete();
    end
  endtask
`endif

  task automatic test_pcsreset();
    int   p;
    int   pcs_f = -1;
    bit   pma_hit = 1'b0;
    bit   seen = 1'b0;
    exp_t e;
    tick();
    p = cyc;
    bus.TXPCSRESET = 1'b1;
    tick();
    bus.TXPCSRESET = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.pma_reset, bus.pcs_reset, bus.TXRESETDONE, bus.line_hold}
        !== 4'b0101) begin
      n_bad++;
      $display("FAIL pcs_entry: pma/pcs/done/hold got %b want 0101",
               {bus.pma_reset, bus.pcs_reset, bus.TXRESETDONE,
                bus.line_hold});
    end
    sb.push_back('{p + 10, model_div});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.pma_reset === 1'b1) pma_hit = 1'b1;
      if (pcs_f < 0 && bus.pcs_reset === 1'b0) pcs_f = cyc;
      if (bus.TXRESETDONE === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.cyc || bus.div_sel !== e.div) begin
          n_bad++;
          $display("FAIL pcs_done: at %0d div %0d want %0d div %0d",
                   cyc - p, bus.div_sel, e.cyc - p, e.div);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pcs_timeout: TXRESETDONE got 0 want 1");
      sb.delete();
    end
    n_cmp++;
    if (pma_hit) begin
      n_bad++;
      $display("FAIL pcs_pma: pma_reset got 1 want 0");
    end
    n_cmp++;
    if (pcs_f != p + 9) begin
      n_bad++;
      $display("FAIL pcs_fall: got %0d want 9", pcs_f - p);
    end
  endtask

  task automatic test_userrdy();
    tick();
    bus.TXUSERRDY = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus.TXRESETDONE, bus.line_hold} !== 2'b01) begin
      n_bad++;
      $display("FAIL userrdy_drop: done/hold got %b want 01",
               {bus.TXRESETDONE, bus.line_hold});
    end
    tick(3);
    @(negedge clk);
    n_cmp++;
    if ({bus.TXRESETDONE, bus.line_hold} !== 2'b01) begin
      n_bad++;
      $display("FAIL userrdy_wait: done/hold got %b want 01",
               {bus.TXRESETDONE, bus.line_hold});
    end
    tick();
    bus.TXUSERRDY = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.TXRESETDONE !== 1'b0) begin
      n_bad++;
      $display("FAIL userrdy_early: done got %b want 0", bus.TXRESETDONE);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus.TXRESETDONE, bus.line_hold, bus.div_sel}
        !== {1'b1, 1'b0, model_div}) begin
      n_bad++;
      $display("FAIL userrdy_back: done/hold/div got %b/%b/%0d want 1/0/%0d",
               bus.TXRESETDONE, bus.line_hold, bus.div_sel, model_div);
    end
  endtask

  task automatic test_gttxreset();
    int   g;
    int   pulses = 0;
    bit   seen = 1'b0;
    exp_t e;
`ifdef GTXE2_TX_RATE_CHANGE_EN
    tick();
    bus.TXRATE = 3'b110;
    model_div = 3'd1;
    tick(4);
    @(negedge clk);
    n_cmp++;
    if ({bus.line_hold, bus.TXRESETDONE, bus.div_sel}
        !== {1'b1, 1'b1, model_div}) begin
      n_bad++;
      $display("FAIL gtt_hold: hold/done/div got %b/%b/%0d want 1/1/%0d",
               bus.line_hold, bus.TXRESETDONE, bus.div_sel, model_div);
    end
`endif
    tick();
    g = cyc;
    bus.GTTXRESET = 1'b1;
    sb.push_back('{g + 26, model_div});
    tick();
    bus.GTTXRESET = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.pma_reset, bus.pcs_reset, bus.TXRESETDONE, bus.TXRATEDONE,
         bus.div_sel} !== {4'b1100, model_div}) begin
      n_bad++;
      $display("FAIL gtt_entry: pma/pcs/done/rdone/div got %b want %b",
               {bus.pma_reset, bus.pcs_reset, bus.TXRESETDONE,
                bus.TXRATEDONE, bus.div_sel}, {4'b1100, model_div});
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.TXRATEDONE === 1'b1) pulses++;
      if (bus.TXRESETDONE === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== e.cyc || bus.div_sel !== e.div) begin
          n_bad++;
          $display("FAIL gtt_done: at %0d div %0d want %0d div %0d",
                   cyc - g, bus.div_sel, e.cyc - g, e.div);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gtt_timeout: TXRESETDONE got 0 want 1");
      sb.delete();
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL gtt_rdone: pulses got %0d want 0", pulses);
    end
  endtask

`ifndef GTXE2_TX_RATE_CHANGE_EN
  task automatic test_rate_ignored();
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.TXRATE = 3'($urandom_range(0, 7));
      @(negedge clk);
      n_cmp++;
      if ({bus.TXRATEDONE, bus.line_hold, bus.div_sel}
          !== {2'b00, model_div}) begin
        n_bad++;
        $display("FAIL rate_ignored: rdone/hold/div got %b/%b/%0d want 0/0/%0d",
                 bus.TXRATEDONE, bus.line_hold, bus.div_sel, model_div);
      end
    end
    tick();
    bus.TXRATE = 3'b000;
  endtask
`endif

  task automatic test_async_reset();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.TXRESETDONE, bus.TXRATEDONE, bus.pma_reset, bus.pcs_reset,
         bus.line_hold} !== 5'b00111) begin
      n_bad++;
      $display("FAIL async_reset: done/rdone/pma/pcs/hold got %b want 00111",
               {bus.TXRESETDONE, bus.TXRATEDONE, bus.pma_reset,
                bus.pcs_reset, bus.line_hold});
    end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_powerup();
`ifdef GTXE2_TX_RATE_CHANGE_EN
    test_rate_change();
    test_rate_restart();
`endif
    test_pcsreset();
    test_userrdy();
    test_gttxreset();
`ifndef GTXE2_TX_RATE_CHANGE_EN
    test_rate_ignored();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run time got 200000 want less");
    $fatal(1, "watchdog expired");
  end
endmodule
